// File: rtl/interp_pkg.sv
// Shared state type, shift helper and parameter guard for the linear interpolator.
`ifndef INTERP_PKG_SV
`define INTERP_PKG_SV

`define INTERP_ASSERT_POW2(l) \
  if (((l) < 2) || (((l) & ((l) - 1)) != 0)) begin : g_bad_upsample_factor \
    $error("UPSAMPLE_FACTOR must be a power of two >= 2"); \
  end

package interp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Falls back to 1 so a bad factor still elaborates far enough for the guard to report it.
  function automatic int shift_amt(input int factor);
    return (factor < 2) ? 1 : $clog2(factor);
  endfunction

endpackage

`endif

// File: rtl/interp_ramp_gen.sv
// Ramp datapath: loads base/step from two samples, then walks acc by diff once per beat.
module interp_ramp_gen
  import interp_pkg::*;
#(
  parameter int UPSAMPLE_FACTOR = 16,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [DATA_WIDTH-1:0] target,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  last
);

  localparam int LOG2_L = shift_amt(UPSAMPLE_FACTOR);
  localparam int ACC_W  = DATA_WIDTH + LOG2_L + 1;

  logic signed [DATA_WIDTH:0] diff_q, diff_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_L-1:0]          cnt_q, cnt_d;
  logic                       unused_acc_msb;

  always_comb begin
    diff_d = diff_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    if (load) begin
      diff_d = $signed({target[DATA_WIDTH-1], target}) - $signed({base[DATA_WIDTH-1], base});
      acc_d  = $signed({base[DATA_WIDTH-1], base, {LOG2_L{1'b0}}});
      cnt_d  = '0;
    end else if (step) begin
      acc_d = acc_q + $signed({{LOG2_L{diff_q[DATA_WIDTH]}}, diff_q});
      cnt_d = cnt_q + LOG2_L'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      diff_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      diff_q <= diff_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

  // Arithmetic shift then truncate is just this slice; the ramp never leaves [prev, cur].
  assign data_out       = acc_q[LOG2_L +: DATA_WIDTH];
  assign last           = &cnt_q;
  assign unused_acc_msb = acc_q[ACC_W-1];

endmodule

// File: rtl/linear_interpolator.sv
// Upsampling linear interpolator with valid/ready on both sides.
// Optional INTERP_ZOH_EN adds a zoh_mode input for zero-order-hold bursts.
//
//   state | meaning
//   IDLE  | waiting for a sample, in_ready high, no output
//   EMIT  | emitting UPSAMPLE_FACTOR beats from prev toward cur
module linear_interpolator
  import interp_pkg::*;
#(
  parameter int UPSAMPLE_FACTOR = 16,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out
`ifdef INTERP_ZOH_EN
  ,
  input  logic                  zoh_mode
`endif
);

  `INTERP_ASSERT_POW2(UPSAMPLE_FACTOR)

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] ramp_base;
  logic                  ramp_load;
  logic                  ramp_step;
  logic                  ramp_last;
  logic                  zoh_sel;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    prev_d    = prev_q;
    out_valid = 1'b0;
    in_ready  = 1'b0;
`ifdef INTERP_ZOH_EN
    zoh_sel   = zoh_mode;
`else
    zoh_sel   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      EMIT: begin
        out_valid = 1'b1;
        // Look-ahead ready on the final beat keeps back-to-back bursts gapless.
        in_ready  = ramp_last && out_ready;
        if (out_ready && ramp_last) begin
          prev_d  = cur_q;
          state_d = IDLE;
        end
      end
    endcase

    ramp_load = in_valid && in_ready;
    ramp_step = out_valid && out_ready && !ramp_last;
    if (ramp_load) begin
      cur_d   = data_in;
      state_d = EMIT;
    end

    // On a streaming reload cur is about to become prev, so it is the ramp start.
    ramp_base = (state_q == EMIT) ? cur_q : prev_q;
    if (zoh_sel) ramp_base = data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
    end
  end

  interp_ramp_gen #(
    .UPSAMPLE_FACTOR(UPSAMPLE_FACTOR),
    .DATA_WIDTH     (DATA_WIDTH)
  ) u_ramp (
    .clk     (clk),
    .rst     (rst),
    .load    (ramp_load),
    .step    (ramp_step),
    .base    (ramp_base),
    .target  (data_in),
    .data_out(data_out),
    .last    (ramp_last)
  );

endmodule
